pipelined_mux_n_to_one: RTL
===========================

Name: pipelined_mux_n_to_one

Overview:
- Parametrised N-channel, W-bit multiplexer built as a tree of 4:1 levels, with a register after every level.
- Adds valid tracking, a pipeline hold, out-of-range select detection and an automatic round-robin scan mode.
- Generalises the existing fixed 16:1 × 32-bit combinational mux.
- Sits between register-file/bus sources and downstream consumers that need a timing-closed wide mux.

Parameters:
- WIDTH, 32: bits per channel.
- CHANNELS, 16: number of input channels, 2..64.
- SEL_WIDTH, 5: select width; must be ≥ ceil(log2(CHANNELS)).
- LEVELS, derived = ceil(log4(CHANNELS)): number of 4:1 tree levels, which is also the latency in cycles (default 2).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- data_in  in  CHANNELS*WIDTH  flattened inputs; channel k at [k*WIDTH +: WIDTH]; channel 0 in the LSBs.
- select  in  SEL_WIDTH  channel index, used when mode=0.
- mode  in  1  0 = manual select; 1 = round-robin scan.
- in_valid  in  1  qualifies data_in/select this cycle.
- hold  in  1  1 = freeze the whole pipeline and the scan counter.
- data_out  out  WIDTH  selected channel data.
- out_valid  out  1  data_out is valid.
- out_channel  out  SEL_WIDTH  channel index that produced data_out.
- select_error  out  1  the index for this beat was ≥ CHANNELS.

Behaviour:
- Reset (reset_n=0 at a rising edge): all pipeline data, valid, channel and error registers clear to 0; scan counter clears to 0. Outputs read 0 from the next cycle on.
- Reset asserted mid-operation discards all in-flight beats; no partial output.
- Reset has priority over hold.
- Effective index per beat:
  - mode=0: select.
  - mode=1: scan_count; select is ignored.
- Advance: the pipeline advances when hold=0. Stage 0 captures in_valid, data and index every advancing cycle, including invalid cycles, which become bubbles.
- Hold: hold=1 keeps every stage register and scan_count unchanged. Inputs presented during hold are dropped.
- Latency: a beat presented with hold=0 at cycle t appears on the outputs after LEVELS advancing edges; with defaults and no hold, that is cycle t+2.
- Sideband alignment: out_valid, out_channel and select_error travel alongside the data through every stage.
- Tree structure:
  - Level i uses index bits [2i+1:2i] to pick 1 of 4 groups.
  - Groups padded beyond CHANNELS read as all-zero.
  - Index bits above 2*LEVELS-1 are not used for selection; they feed only the error check.
- Out-of-range index (≥ CHANNELS): data_out=0, select_error=1, out_channel = the offending index, out_valid follows in_valid.
- Scan mode:
  - scan_count increments on each cycle with in_valid=1, hold=0 and mode=1.
  - It wraps from CHANNELS-1 to 0, so it never produces an error.
  - Switching mode does not reset scan_count; it resumes from its last value.
- Invalid beats (in_valid=0) still move data through the pipeline, but out_valid=0 and select_error=0 for them.
- No backpressure: the downstream side must accept every out_valid beat or assert hold.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, then 1 → data_out=0, out_valid=0, out_channel=0, select_error=0 for every cycle after reset.
- Manual select sweep: channel k = 32'hA000_0000+k, mode=0, in_valid=1, select=0..15 on consecutive cycles → data_out=A000_0000+k, out_channel=k, out_valid=1 exactly 2 cycles later, back-to-back.
- Out of range: select=16, then 31 → data_out=0, select_error=1, out_channel=16 then 31, out_valid=1.
- Scan wrap: mode=1, in_valid=1 for 18 cycles → out_channel sequence 0..15,0,1; a 3-cycle in_valid=0 gap mid-sequence leaves the sequence unbroken, with out_valid=0 during the gap.
- Hold mid-stream: issue beats 3,4,5, then assert hold for 4 cycles after beat 4 enters → outputs frozen for 4 cycles, then beats 4 and 5 emerge in order with no loss or duplication; scan_count frozen during hold.
- Reset mid-flight: two valid beats in the pipeline, reset_n=0 for one cycle → next output out_valid=0, and both beats are never emitted.

Source files
------------

// File: rtl/pipelined_mux_n_to_one.sv
// N-channel, W-bit multiplexer built from registered 4:1 levels, carrying valid,
// channel index and out-of-range error alongside the data; optional round-robin scan.
module pipelined_mux_n_to_one #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 16,
  parameter int SEL_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_WIDTH-1:0]      select,
  input  logic                      mode,
  input  logic                      in_valid,
  input  logic                      hold,
  output logic [WIDTH-1:0]          data_out,
  output logic                      out_valid,
  output logic [SEL_WIDTH-1:0]      out_channel,
  output logic                      select_error
);

  localparam int LEVELS = (CHANNELS <= 4) ? 1 : (CHANNELS <= 16) ? 2 : 3;
  localparam int PAD    = 4 ** LEVELS;
  localparam logic [SEL_WIDTH:0]   CH_LIMIT  = (SEL_WIDTH + 1)'(CHANNELS);
  localparam logic [SEL_WIDTH-1:0] SCAN_LAST = SEL_WIDTH'(CHANNELS - 1);

  logic [SEL_WIDTH-1:0] scan_q;
  logic [SEL_WIDTH-1:0] scan_d;
  logic [SEL_WIDTH-1:0] index;
  logic                 out_of_range;
  logic [PAD*WIDTH-1:0] data_pad;

  assign index        = mode ? scan_q : select;
  assign out_of_range = ({1'b0, index} >= CH_LIMIT);

  // Channels beyond CHANNELS read as zero so the tree is always a full 4-ary tree.
  always_comb begin
    data_pad = '0;
    data_pad[CHANNELS*WIDTH-1:0] = data_in;
  end

  always_comb begin
    scan_d = scan_q;
    if (mode && in_valid && !hold) begin
      scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SEL_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      scan_q <= '0;
    end else begin
      scan_q <= scan_d;
    end
  end

  genvar gi, go;
  generate
    for (gi = 0; gi < LEVELS; gi++) begin : gen_lvl
      localparam int NOUT = 4 ** (LEVELS - 1 - gi);

      logic [4*NOUT*WIDTH-1:0] din;
      logic [SEL_WIDTH-1:0]    idx_in;
      logic                    vld_in;
      logic                    err_in;
      logic                    zero_in;
      logic [1:0]              sel;
      logic [NOUT*WIDTH-1:0]   mux;
      logic [NOUT*WIDTH-1:0]   data_d;
      logic [NOUT*WIDTH-1:0]   data_q;
      logic [SEL_WIDTH-1:0]    idx_q;
      logic                    valid_q;
      logic                    err_q;

      if (gi == 0) begin : g_src
        assign din     = data_pad;
        assign idx_in  = index;
        assign vld_in  = in_valid;
        assign err_in  = in_valid && out_of_range;
        assign zero_in = out_of_range;
      end else begin : g_src
        assign din     = gen_lvl[gi-1].data_q;
        assign idx_in  = gen_lvl[gi-1].idx_q;
        assign vld_in  = gen_lvl[gi-1].valid_q;
        assign err_in  = gen_lvl[gi-1].err_q;
        assign zero_in = 1'b0;
      end

      // Index bits above 2*LEVELS-1 never steer the tree; zero-extension covers narrow selects.
      assign sel = 2'({{(2*LEVELS){1'b0}}, idx_in} >> (2 * gi));

      for (go = 0; go < NOUT; go++) begin : gen_out
        assign mux[go*WIDTH +: WIDTH] = din[(4*go + int'(sel))*WIDTH +: WIDTH];
      end

      // Out-of-range beats are blanked on entry, so later levels just pass zero along.
      assign data_d = zero_in ? '0 : mux;

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          data_q  <= '0;
          idx_q   <= '0;
          valid_q <= 1'b0;
          err_q   <= 1'b0;
        end else if (!hold) begin
          data_q  <= data_d;
          idx_q   <= idx_in;
          valid_q <= vld_in;
          err_q   <= err_in;
        end
      end
    end
  endgenerate

  assign data_out     = gen_lvl[LEVELS-1].data_q;
  assign out_valid    = gen_lvl[LEVELS-1].valid_q;
  assign out_channel  = gen_lvl[LEVELS-1].idx_q;
  assign select_error = gen_lvl[LEVELS-1].err_q;

endmodule
